// File: rtl/a2d_conv_intf_if.sv
// Bus between the slide-pot sequencer / ADC pins and the a2d_conv_intf SPI master.
// master: the converter's view; slave: the sequencer-plus-ADC side.
`timescale 1ns/1ps
interface a2d_conv_intf_if;
   logic        strt_cnv;
   logic [2:0]  chnnl;
   logic        cnv_cmplt;
   logic [11:0] res;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;

   modport master (
      input  strt_cnv, chnnl, MISO,
      output cnv_cmplt, res, SS_n, SCLK, MOSI
   );

   modport slave (
      output strt_cnv, chnnl, MISO,
      input  cnv_cmplt, res, SS_n, SCLK, MOSI
   );
endinterface

// File: rtl/a2d_conv_intf.sv
// SPI master for an ADC128S-class 8-channel ADC: one request runs an address
// frame, a short SS_n gap, and a data frame that returns the 12-bit result.
`timescale 1ns/1ps
module a2d_conv_intf #(
   parameter int SCLK_DIV_W = 5,
   parameter int GAP_CLKS   = 2
) (
   input logic             clk,
   input logic             rst,
   a2d_conv_intf_if.master bus
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] FRM1 = 3'd1;
   localparam logic [2:0] GAP  = 3'd2;
   localparam logic [2:0] FRM2 = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

   // Divider points: preset lands the first SCLK fall 9 clk into the frame.
   localparam logic [SCLK_DIV_W-1:0] DIV_ONES   = '1;
   localparam logic [SCLK_DIV_W-1:0] DIV_PRESET = DIV_ONES - SCLK_DIV_W'(8);
   localparam logic [SCLK_DIV_W-1:0] DIV_RISE   = DIV_ONES >> 1;
   localparam logic [SCLK_DIV_W-1:0] DIV_LAST   = DIV_ONES - SCLK_DIV_W'(2);

   logic [2:0]            state;
   logic [SCLK_DIV_W-1:0] div;
   logic [15:0]           shift_reg;
   logic [4:0]            bit_cnt;
   logic                  capture;
   logic                  ss_n;
   logic [GAP_W-1:0]      gap_cnt;
   logic [2:0]            chnnl_lat;
   logic [11:0]           res;
   logic                  cnv_cmplt;
   logic                  in_frame;
   logic                  accept;

   assign in_frame = (state == FRM1) || (state == FRM2);
   assign accept   = bus.strt_cnv && ((state == IDLE) || (state == DONE));

   // NOTE: all state uses non-blocking assignments; where two branches assign
   // the same flop in one edge, the later statement deliberately takes effect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         div       <= '1;
         shift_reg <= '0;
         bit_cnt   <= '0;
         capture   <= 1'b0;
         ss_n      <= 1'b1;
         gap_cnt   <= '0;
         chnnl_lat <= '0;
         res       <= '0;
         cnv_cmplt <= 1'b0;
      end else begin
         case (state)
            FRM1, FRM2: begin
               div <= div + 1'b1;
               if (div == DIV_RISE) begin
                  capture <= bus.MISO;
                  bit_cnt <= bit_cnt + 1'b1;
               end
               if ((bit_cnt == 5'd16) && (div == DIV_LAST)) begin
                  // Final shift happens early so SS_n rises with SCLK still high.
                  shift_reg <= {shift_reg[14:0], capture};
                  ss_n      <= 1'b1;
                  div       <= '1;
                  gap_cnt   <= '0;
                  state     <= (state == FRM1) ? GAP : DONE;
               end else if ((div == DIV_ONES) && (bit_cnt != 5'd0)) begin
                  shift_reg <= {shift_reg[14:0], capture};
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt + 1'b1;
               if (gap_cnt == GAP_W'(GAP_CLKS - 1)) begin
                  shift_reg <= {2'b00, chnnl_lat, 11'h000};
                  div       <= DIV_PRESET;
                  bit_cnt   <= '0;
                  ss_n      <= 1'b0;
                  state     <= FRM2;
               end
            end
            DONE: begin
               res       <= shift_reg[11:0];
               cnv_cmplt <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (accept) begin
            chnnl_lat <= bus.chnnl;
            shift_reg <= {2'b00, bus.chnnl, 11'h000};
            cnv_cmplt <= 1'b0;
            div       <= DIV_PRESET;
            bit_cnt   <= '0;
            ss_n      <= 1'b0;
            state     <= FRM1;
         end
      end
   end

   assign bus.SS_n      = ss_n;
   assign bus.SCLK      = ~in_frame | ss_n | div[SCLK_DIV_W-1];
   assign bus.MOSI      = shift_reg[15];
   assign bus.res       = res;
   assign bus.cnv_cmplt = cnv_cmplt;

endmodule

// File: tb/tb_a2d_conv_intf.sv
// Directed bench for a2d_conv_intf: an ADC model answers with the result for the
// channel addressed in the previous frame; a frame monitor records SPI timing.
`timescale 1ns/1ps
module tb_a2d_conv_intf;

   logic clk = 1'b0;
   logic rst;
   logic miso;

   a2d_conv_intf_if bus ();
   assign bus.MISO = miso;

   a2d_conv_intf #(.SCLK_DIV_W(5), .GAP_CLKS(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- ADC model and frame monitor ----------------
   typedef struct {
      logic [15:0] mosi;
      int          rises;
      int          low_clk;
      int          first_fall;
      bit          period_ok;
      logic        sclk_at_end;
   } frame_t;

   frame_t      frames_q[$];
   int          frames_started = 0;
   logic [11:0] adc_data [8];
   logic [2:0]  next_ch = 3'd0;
   logic [15:0] adc_word;
   logic [15:0] mw;
   int          rises;
   int          ff;
   bit          pok;
   bit          in_frame = 1'b0;
   logic        prev_sclk = 1'b1;
   longint      t_fall;
   longint      t_rise;

   initial miso = 1'b0;

   always @(bus.SS_n, bus.SCLK) begin
      if (!in_frame && bus.SS_n === 1'b0) begin
         in_frame = 1'b1;
         frames_started++;
         t_fall   = $time;
         rises    = 0;
         mw       = '0;
         ff       = -1;
         pok      = 1'b1;
         adc_word = {4'h0, adc_data[next_ch]};
         miso     = adc_word[15];
      end else if (in_frame && bus.SS_n === 1'b1) begin
         frame_t f;
         in_frame      = 1'b0;
         f.mosi        = mw;
         f.rises       = rises;
         f.low_clk     = int'(($time - t_fall) / 10);
         f.first_fall  = ff;
         f.period_ok   = pok;
         f.sclk_at_end = bus.SCLK;
         frames_q.push_back(f);
         next_ch = mw[13:11];
      end else if (in_frame && bus.SCLK !== prev_sclk) begin
         if (bus.SCLK === 1'b1) begin
            if (rises > 0 && ($time - t_rise) != 320) pok = 1'b0;
            t_rise = $time;
            rises++;
            mw = {mw[14:0], bus.MOSI};
         end else begin
            if (ff < 0) ff = int'(($time - t_fall) / 10);
            miso = (rises < 16) ? adc_word[15 - rises] : 1'b0;
         end
      end
      prev_sclk = bus.SCLK;
   end

   // ---------------- helpers ----------------
   task automatic pulse_start(input logic [2:0] ch);
      bus.strt_cnv = 1'b1;
      bus.chnnl    = ch;
      @(negedge clk);
      bus.strt_cnv = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (bus.cnv_cmplt !== 1'b1 && cyc < 1300) begin
         @(negedge clk);
         cyc++;
      end
      if (bus.cnv_cmplt !== 1'b1) check("cmplt_timeout", 32'(cyc), 32'd1041);
   endtask

   typedef struct {
      logic [2:0]  ch;
      logic [11:0] adc_val;
      logic [15:0] exp_mosi;
      logic [11:0] exp_res;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int cyc;
      int base;

      vecs[0] = '{3'd5, 12'hA5C, 16'h2800, 12'hA5C};
      vecs[1] = '{3'd0, 12'h000, 16'h0000, 12'h000};
      vecs[2] = '{3'd7, 12'hFFF, 16'h3800, 12'hFFF};
      vecs[3] = '{3'd2, 12'h5A3, 16'h1000, 12'h5A3};
      vecs[4] = '{3'd6, 12'h3C1, 16'h3000, 12'h3C1};
      for (int i = 0; i < 8; i++) adc_data[i] = 12'h000;

      rst          = 1'b1;
      bus.strt_cnv = 1'b0;
      bus.chnnl    = 3'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Idle after reset: pins quiet, no result.
      repeat (100) begin
         @(negedge clk);
         check("idle_pins", {bus.SS_n, bus.SCLK, bus.cnv_cmplt, bus.res},
               {1'b1, 1'b1, 1'b0, 12'h000});
      end

      // Table-driven conversions.
      for (int i = 0; i < 5; i++) begin
         adc_data[vecs[i].ch] = vecs[i].adc_val;
         base = frames_started;
         pulse_start(vecs[i].ch);
         check("cmplt_clear_on_start", bus.cnv_cmplt, 1'b0);
         wait_done(cyc);
         check("latency_window", (cyc >= 1040 && cyc <= 1044), 1'b1);
         check("res", bus.res, vecs[i].exp_res);
         check("frames_per_conv", 32'(frames_started - base), 32'd2);
         if (frames_q.size() >= 2) begin
            frame_t f1;
            frame_t f2;
            f1 = frames_q[frames_q.size() - 2];
            f2 = frames_q[frames_q.size() - 1];
            check("f1_mosi", f1.mosi, vecs[i].exp_mosi);
            check("f1_rises", 32'(f1.rises), 32'd16);
            check("f2_rises", 32'(f2.rises), 32'd16);
            check("f1_low_clk", 32'(f1.low_clk), 32'd519);
            check("f2_low_clk", 32'(f2.low_clk), 32'd519);
            check("f1_first_fall", 32'(f1.first_fall), 32'd9);
            check("sclk_period", {f1.period_ok, f2.period_ok}, 2'b11);
            check("sclk_high_at_ss_rise", {f1.sclk_at_end, f2.sclk_at_end}, 2'b11);
         end else begin
            check("frame_records", 32'(frames_q.size()), 32'd2);
         end
         repeat (50) @(negedge clk);
         check("cmplt_sticky", {bus.cnv_cmplt, bus.res}, {1'b1, vecs[i].exp_res});
      end

      // Back-to-back: second start on the clk after cnv_cmplt rises.
      adc_data[0] = 12'h000;
      adc_data[7] = 12'hFFF;
      pulse_start(3'd0);
      wait_done(cyc);
      check("b2b_res0", bus.res, 12'h000);
      pulse_start(3'd7);
      check("b2b_cmplt_cleared", bus.cnv_cmplt, 1'b0);
      wait_done(cyc);
      check("b2b_res7", bus.res, 12'hFFF);

      // Start pulse and channel change during FRM1 must be ignored.
      adc_data[3] = 12'h123;
      adc_data[6] = 12'h6E6;
      base = frames_started;
      pulse_start(3'd3);
      repeat (200) @(negedge clk);
      pulse_start(3'd6);
      wait_done(cyc);
      check("ignore_res", bus.res, 12'h123);
      check("ignore_frames", 32'(frames_started - base), 32'd2);
      repeat (1200) @(negedge clk);
      check("ignore_no_extra", {32'(frames_started - base), 15'(bus.SS_n), bus.cnv_cmplt},
            {32'd2, 15'd1, 1'b1});

      // Reset 300 clk into FRM2.
      adc_data[4] = 12'h4C4;
      base = frames_started;
      pulse_start(3'd4);
      cyc = 0;
      while (frames_started != base + 2 && cyc < 1200) begin
         @(negedge clk);
         cyc++;
      end
      check("frm2_started", 32'(frames_started - base), 32'd2);
      repeat (300) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_frame", {bus.SS_n, bus.SCLK, bus.cnv_cmplt, bus.res},
            {1'b1, 1'b1, 1'b0, 12'h000});
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("post_rst_idle", {bus.SS_n, bus.cnv_cmplt, bus.res}, {1'b1, 1'b0, 12'h000});
      adc_data[1] = 12'h1B1;
      pulse_start(3'd1);
      wait_done(cyc);
      check("post_rst_res", bus.res, 12'h1B1);
      check("post_rst_latency", (cyc >= 1040 && cyc <= 1044), 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
